uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes, power of two, 2..256.
REQ-002 SHALL have parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe; one byte per cycle.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  count == DEPTH.
REQ-008 SHALL have port empty  output  1  count == 0.
REQ-009 SHALL have port count  output  AW+1  bytes currently stored.
REQ-010 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-011 SHALL have port tx_send  output  1  one-cycle send pulse to the downstream uart_tx.
REQ-012 SHALL have port tx_data  output  8  byte presented with tx_send, held until the next send.
REQ-013 SHALL have port tx_busy  input  1  busy output of the downstream uart_tx.

Function
REQ-014 SHALL store bytes in a DEPTH-entry circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write when wr_en=1 and full=0; when full=1, SHALL drop the byte, leave buffer and count unchanged, and set overflow.
REQ-016 SHALL accept the write on a cycle where a pop also occurs even when full=1; count then stays unchanged.
REQ-017 SHALL register full, empty and count, each updated the cycle after the causing write/pop.
REQ-018 SHALL implement FSM states IDLE, SEND, WAIT_START, WAIT_DONE.
REQ-019 IDLE: if empty=0 and tx_busy=0 -> SEND, loading tx_data from the head entry.
REQ-020 SEND: assert tx_send for exactly one cycle, pop the head (except REQ-027), -> WAIT_START.
REQ-021 WAIT_START: stay until tx_busy=1, then -> WAIT_DONE.
REQ-022 WAIT_DONE: stay until tx_busy=0, then -> IDLE.
REQ-023 A byte written into an empty queue at edge N with the FSM in IDLE and tx_busy=0 SHALL produce tx_send=1 during the cycle after edge N+1 (two-cycle latency).
REQ-024 SHALL never assert tx_send while tx_busy=1 or in two consecutive cycles.
REQ-025 Bytes SHALL leave in write order with none duplicated or lost, except drops under REQ-015.

Reset
REQ-026 On reset=1, asynchronously: pointers=0, count=0, empty=1, full=0, overflow=0, tx_send=0, tx_data=8'h00, FSM=IDLE, cr_pending=0; buffer contents are not reset; reset mid-frame discards queued bytes, and the downstream frame in flight is not aborted.

Configuration
REQ-027 With macro UART_TXQ_CRLF_EN defined, a head byte 8'h0A with cr_pending=0 SHALL be sent as 8'h0D without popping and set cr_pending=1; the next pass through SEND SHALL send 8'h0A, pop it, and clear cr_pending; cr_pending is otherwise 0.
REQ-028 Without UART_TXQ_CRLF_EN, 8'h0A SHALL be sent unchanged, and the cr_pending logic SHALL be absent.

Verification
REQ-029 Reset, write 8'h55 with tx_busy=0 -> tx_send one cycle, two cycles after the write edge, tx_data=8'h55, empty=1 afterwards.
REQ-030 Write 8'h01..8'h10 back-to-back with tx_busy=1 held -> full=1, count=16, no tx_send; a 17th write -> overflow=1, count=16.
REQ-031 Write three bytes with tx_busy from uart_tx (12 MHz/115200) -> tx carries 8'hA1, 8'hA2, 8'hA3 in order, with no send while busy.
REQ-032 full=1 with a simultaneous write and pop -> count stays 16 and the new byte appears last.
REQ-033 With UART_TXQ_CRLF_EN, write 8'h41, 8'h0A -> sends 8'h41, 8'h0D, 8'h0A; without the macro -> sends 8'h41, 8'h0A.
REQ-034 Assert reset in WAIT_DONE with 5 bytes queued -> count=0, overflow=0, tx_send=0, FSM=IDLE immediately; no further sends.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a downstream uart_tx through a
// send/busy handshake. The FIFO is a DEPTH-entry circular buffer with
// registered full/empty/count flags and a sticky overflow flag.
// Optional feature: define UART_TXQ_CRLF_EN to expand each LF (8'h0A)
// into CR LF (8'h0D, 8'h0A) on the way out.
`timescale 1ns/1ps

module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_send,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          load;
  logic [AW:0]   count_next;
  logic [7:0]    head;
  logic [7:0]    send_byte;

  assign head = mem[rd_ptr];

`ifdef UART_TXQ_CRLF_EN
  logic cr_pending;
  logic lf_expand;

  // An LF at the head that has not yet had its CR sent goes out as CR first
  // and stays in the queue; the following pass sends the LF itself.
  assign lf_expand = (head == 8'h0A) && !cr_pending;
  assign send_byte = lf_expand ? 8'h0D : head;
`else
  assign send_byte = head;
`endif

  // A write is taken when there is room, or when a pop frees the slot in
  // the same cycle; the head was already copied to tx_data, so overwriting
  // its slot on a full-queue write+pop is safe.
  assign push       = wr_en && (!full || pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  // Next-state and per-cycle strobes for the send handshake.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        state_next = WAIT_START;
`ifdef UART_TXQ_CRLF_EN
        pop        = !lf_expand;
`else
        pop        = 1'b1;
`endif
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, occupancy flags and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Buffer storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Send pulse and held byte toward the downstream transmitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_send <= load;
      if (load) begin
        tx_data <= send_byte;
      end
    end
  end

`ifdef UART_TXQ_CRLF_EN
  // Remember that the CR for the current head LF has already been sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_pending <= 1'b0;
    end else if (state == SEND) begin
      cr_pending <= lf_expand;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: directed table/sequence checks plus a
// randomized run scored against a queue-based reference model. A simple
// downstream model raises tx_busy for frame_len cycles after each send.
`timescale 1ns/1ps

module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        force_busy;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  // Downstream transmitter: busy for frame_len cycles after a send.
  int busy_cnt  = 0;
  int frame_len = 4;
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= frame_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  // Send logger and protocol watcher.
  logic [7:0] log_data [1024];
  int         log_wr    = 0;
  int         viol      = 0;
  logic       prev_send = 1'b0;
  always @(negedge clk) begin
    if (tx_send) begin
      if (tx_busy || prev_send) viol <= viol + 1;
      log_data[log_wr % 1024] <= tx_data;
      log_wr <= log_wr + 1;
    end
    prev_send <= tx_send;
  end

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mq [$];
  logic       m_ovf;
  logic       m_cr;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       busy;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_bus_idle(input int limit);
    int k = 0;
    while (tx_busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("bus_idle", int'(tx_busy), 0);
  endtask

  task automatic wait_sends(input int target, input int limit, input string name);
    int k = 0;
    while (log_wr < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_send_count"}, log_wr, target);
  endtask

  // Expected bytes on the wire for one written byte.
  task automatic push_exp(input logic [7:0] b);
`ifdef UART_TXQ_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic compare_log(input string name, input int base);
    check({name, "_len"}, log_wr - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), int'(log_data[(base + i) % 1024]), int'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // One cycle of the randomized run against the queue reference model.
  task automatic model_cycle(input bit allow_wr, input int prob);
    bit         do_pop;
    bit         w;
    bit         acc;
    logic [7:0] d;
    logic [7:0] e;
    check("rnd_count", int'(count), mq.size());
    check("rnd_full", int'(full), int'(mq.size() == DEPTH));
    check("rnd_empty", int'(empty), int'(mq.size() == 0));
    check("rnd_overflow", int'(overflow), int'(m_ovf));
    do_pop = 1'b0;
    if (tx_send) begin
      check("rnd_send_nonempty", int'(mq.size() != 0), 1);
      if (mq.size() != 0) begin
        e      = mq[0];
        do_pop = 1'b1;
`ifdef UART_TXQ_CRLF_EN
        if (mq[0] == 8'h0A && !m_cr) begin
          e      = 8'h0D;
          do_pop = 1'b0;
          m_cr   = 1'b1;
        end else begin
          m_cr   = 1'b0;
        end
`endif
        check("rnd_tx_data", int'(tx_data), int'(e));
      end
    end
    w         = allow_wr && ($urandom_range(0, 99) < prob);
    d         = 8'($urandom);
    wr_en     = w;
    wr_data   = d;
    frame_len = $urandom_range(2, 10);
    acc = w && ((mq.size() < DEPTH) || do_pop);
    if (w && !acc) m_ovf = 1'b1;
    if (do_pop) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base2;
    int k;

    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    force_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_send", int'(tx_send), 0);
    check("rst_tx_data", int'(tx_data), 0);
    reset = 1'b0;

    // Two-cycle latency of a single byte
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    check("lat_no_send_yet", int'(tx_send), 0);
    check("lat_count", int'(count), 1);
    @(negedge clk);
    check("lat_send", int'(tx_send), 1);
    check("lat_data", int'(tx_data), 8'h55);
    @(negedge clk);
    check("lat_single_pulse", int'(tx_send), 0);
    check("lat_empty_after", int'(empty), 1);
    wait_bus_idle(100);

    // Fill to full with the transmitter busy, then one more write
    for (int i = 0; i < 17; i++) begin
      vecs[i].wr        = 1'b1;
      vecs[i].data      = 8'(i + 1);
      vecs[i].busy      = 1'b1;
      vecs[i].exp_count = (i + 1 > DEPTH) ? DEPTH : i + 1;
      vecs[i].exp_full  = (i >= DEPTH - 1);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = (i == DEPTH);
    end
    do_reset();
    base = log_wr;
    for (int i = 0; i < 17; i++) begin
      wr_en      = vecs[i].wr;
      wr_data    = vecs[i].data;
      force_busy = vecs[i].busy;
      @(negedge clk);
      check($sformatf("fill%0d_count", i), int'(count), vecs[i].exp_count);
      check($sformatf("fill%0d_full", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("fill%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
      check($sformatf("fill%0d_overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("fill_no_send", log_wr - base, 0);
    for (int i = 1; i <= 16; i++) push_exp(8'(i));

    // Write on the pop cycle of a full queue
    frame_len  = 20;
    force_busy = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_send && k < 10);
    check("wp_send_seen", int'(tx_send), 1);
    check("wp_first_byte", int'(tx_data), 8'h01);
    write_byte(8'h77);
    check("wp_count", int'(count), 16);
    check("wp_full", int'(full), 1);
    check("wp_overflow_sticky", int'(overflow), 1);
    push_exp(8'h77);
    wait_sends(base + exp_q.size(), 2000, "wp");
    compare_log("wp", base);
    wait_bus_idle(100);

    // Three bytes at 12 MHz / 115200 frame timing
    do_reset();
    frame_len = 1040;
    base = log_wr;
    write_byte(8'hA1);
    wr_en = 1'b1; wr_data = 8'hA2; @(negedge clk);
    wr_data = 8'hA3; @(negedge clk);
    wr_en = 1'b0;
    push_exp(8'hA1); push_exp(8'hA2); push_exp(8'hA3);
    wait_sends(base + 3, 4000, "baud");
    compare_log("baud", base);
    wait_bus_idle(1200);

    // LF handling
    do_reset();
    frame_len = 8;
    base = log_wr;
    write_byte(8'h41);
    write_byte(8'h0A);
    push_exp(8'h41); push_exp(8'h0A);
    wait_sends(base + exp_q.size(), 200, "lf");
    compare_log("lf", base);
    wait_bus_idle(100);

    // Reset while waiting on a frame with bytes queued
    do_reset();
    frame_len = 200;
    base = log_wr;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_sends(base + 1, 50, "mid");
    repeat (5) @(negedge clk);
    check("mid_pre_count", int'(count), 5);
    reset = 1'b1;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_tx_send", int'(tx_send), 0);
    check("mid_rst_empty", int'(empty), 1);
    @(negedge clk);
    reset = 1'b0;
    base2 = log_wr;
    repeat (250) @(negedge clk);
    check("mid_no_more_sends", log_wr - base2, 0);
    check("mid_busy_done", int'(tx_busy), 0);
    write_byte(8'h5A);
    @(negedge clk);
    check("mid_idle_send", int'(tx_send), 1);
    check("mid_idle_data", int'(tx_data), 8'h5A);
    wait_bus_idle(300);

    // Randomized run against the reference queue
    do_reset();
    m_ovf = 1'b0;
    m_cr  = 1'b0;
    mq.delete();
    for (int i = 0; i < 300; i++) model_cycle(1'b1, 80);
    for (int i = 0; i < 300; i++) model_cycle(1'b1, 15);
    k = 0;
    while ((mq.size() != 0 || tx_busy) && k < 3000) begin
      model_cycle(1'b0, 0);
      k++;
    end
    check("rnd_drained", mq.size(), 0);

    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
